// File: rtl/bsg_wormhole_router_route_tracker_dor.sv
// Per-input route tracker for a dimension-ordered wormhole router: decodes the
// header destination into a one-hot direction and holds it for the packet body.
//
// state | meaning
// IDLE  | head flit (if valid) is a header; route decoded combinationally
// BODY  | body flits in flight; route_q held until the tail is consumed
module bsg_wormhole_router_route_tracker_dor #(
    parameter int dims_p = 2,
    parameter int cord_markers_pos_p [dims_p:0] = '{5, 4, 0},
    parameter int len_width_p = 4,
    parameter int flit_width_p = 16,
    parameter bit reverse_order_p = 1'b0,
    localparam int cord_w = cord_markers_pos_p[dims_p],
    localparam int dirs_lp = 2*dims_p+1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cord_w-1:0]       my_cord_i,
    input  logic                    reverse_order_i,
    input  logic                    v_i,
    input  logic [flit_width_p-1:0] data_i,
    input  logic                    yumi_i,
    output logic [dirs_lp-1:0]      req_o,
    output logic                    header_o,
    output logic                    tail_o
);

    typedef enum logic {IDLE, BODY} state_e;

    state_e                 state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [dirs_lp-1:0]     route_q, route_d;
    logic [dirs_lp-1:0]     dec;
    logic [dims_p-1:0]      eq, lt;
    logic [cord_w-1:0]      tgt_cord;
    logic [len_width_p-1:0] len;
    logic                   order;
    logic                   pre_eq;
    logic                   unused_hi;

    assign tgt_cord  = data_i[cord_w-1:0];
    assign len       = data_i[cord_w+len_width_p-1:cord_w];
    assign order     = reverse_order_p ^ reverse_order_i;
    assign unused_hi = ^data_i[flit_width_p-1:cord_w+len_width_p];

    for (genvar i = 0; i < dims_p; i++) begin : g_cmp
        localparam int lo = cord_markers_pos_p[i];
        localparam int hi = cord_markers_pos_p[i+1] - 1;
        assign eq[i] = (tgt_cord[hi:lo] == my_cord_i[hi:lo]);
        assign lt[i] = (tgt_cord[hi:lo] <  my_cord_i[hi:lo]);
    end

    // A dimension may route only once every dimension ahead of it in the order matches.
    always_comb begin
        dec    = '0;
        pre_eq = 1'b1;
        dec[0] = &eq;
        for (int i = 0; i < dims_p; i++) begin
            pre_eq = 1'b1;
            for (int j = 0; j < dims_p; j++) begin
                if (order ? (j > i) : (j < i)) pre_eq = pre_eq & eq[j];
            end
            dec[2*i+1] = pre_eq & lt[i];
            dec[2*i+2] = pre_eq & ~eq[i] & ~lt[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        route_d  = route_q;
        req_o    = '0;
        header_o = 1'b0;
        tail_o   = 1'b0;
        case (state_q)
            IDLE: begin
                header_o = v_i;
                tail_o   = v_i && (len == '0);
                if (v_i) req_o = dec;
                if (yumi_i && (len != '0)) begin
                    route_d = dec;
                    cnt_d   = len;
                    state_d = BODY;
                end
            end
            BODY: begin
                tail_o = v_i && (cnt_q == len_width_p'(1));
                if (v_i) req_o = route_q;
                if (yumi_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == len_width_p'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            route_q <= route_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_i)) else $error("yumi_i asserted without v_i");
            assert (!v_i || $onehot(req_o)) else $error("req_o not one-hot while v_i");
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_router_route_tracker_dor.sv
// Directed bench for the DOR route tracker; two instances differ only in default order.
module tb_bsg_wormhole_router_route_tracker_dor;

    localparam logic [4:0] P = 5'b00001;
    localparam logic [4:0] W = 5'b00010;
    localparam logic [4:0] E = 5'b00100;
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] MY = 5'b0_0011;
    localparam logic [4:0] T_E = 5'b1_0101;  // x5/y1
    localparam logic [4:0] T_W = 5'b0_0001;  // x1/y0
    localparam logic [4:0] T_S = 5'b1_0011;  // x3/y1

    typedef struct packed {
        logic [4:0] r0;
        logic [4:0] r1;
        logic       h;
        logic       t;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        reverse_order_i = 1'b0;
    logic        v_i = 1'b0;
    logic        yumi_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [4:0]  req0, req1;
    logic        hdr0, hdr1, tail0, tail1;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    bsg_wormhole_router_route_tracker_dor #(.reverse_order_p(1'b0)) dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .my_cord_i(MY), .reverse_order_i(reverse_order_i),
        .v_i(v_i), .data_i(data_i), .yumi_i(yumi_i),
        .req_o(req0), .header_o(hdr0), .tail_o(tail0));

    bsg_wormhole_router_route_tracker_dor #(.reverse_order_p(1'b1)) dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .my_cord_i(MY), .reverse_order_i(reverse_order_i),
        .v_i(v_i), .data_i(data_i), .yumi_i(yumi_i),
        .req_o(req1), .header_o(hdr1), .tail_o(tail1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] hdr(input logic [3:0] len, input logic [4:0] cord);
        return {7'b0, len, cord};
    endfunction

    task automatic step(input logic v, input logic y, input logic r, input logic [15:0] d,
                        input logic [4:0] e0, input logic [4:0] e1, input logic h, input logic t);
        @(posedge clk_i); #1;
        v_i = v; yumi_i = y; reverse_order_i = r; data_i = d;
        if (v) sb_q.push_back(exp_t'{e0, e1, h, t});
    endtask

    // Monitor: pops one expectation per presented flit, otherwise requires quiet outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (v_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("req_dut0",  32'(req0),  32'(e.r0));
                    chk("req_dut1",  32'(req1),  32'(e.r1));
                    chk("hdr_dut0",  32'(hdr0),  32'(e.h));
                    chk("hdr_dut1",  32'(hdr1),  32'(e.h));
                    chk("tail_dut0", 32'(tail0), 32'(e.t));
                    chk("tail_dut1", 32'(tail1), 32'(e.t));
                end
            end else begin
                chk("idle_outs", 32'({req0, req1, hdr0, tail0, hdr1, tail1}), 32'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // single-flit headers: order selection and basic decode
        step(1, 1, 0, hdr(0, T_E), E, S, 1, 1);
        step(1, 1, 1, hdr(0, T_E), S, E, 1, 1);
        step(1, 1, 0, hdr(0, MY),  P, P, 1, 1);
        step(1, 1, 1, hdr(0, T_W), W, W, 1, 1);

        // len 3 packet, header stalled once, bubbles and garbage in the body
        step(1, 0, 0, hdr(3, T_E), E, S, 1, 0);
        step(1, 1, 0, hdr(3, T_E), E, S, 1, 0);
        step(0, 0, 1, 16'h0000,    0, 0, 0, 0);
        step(1, 0, 1, 16'hFFE3,    E, S, 0, 0);
        step(1, 1, 1, 16'h0001,    E, S, 0, 0);
        step(0, 0, 0, 16'h0013,    0, 0, 0, 0);
        step(1, 1, 0, 16'h0013,    E, S, 0, 0);
        step(1, 0, 1, 16'h0000,    E, S, 0, 1);
        step(1, 1, 0, 16'h0015,    E, S, 0, 1);

        // back-to-back: len 2 to E, then len 0 to P
        step(1, 1, 0, hdr(2, T_E), E, S, 1, 0);
        step(1, 1, 0, 16'h0003,    E, S, 0, 0);
        step(1, 1, 0, 16'h0001,    E, S, 0, 1);
        step(1, 1, 0, hdr(0, MY),  P, P, 1, 1);

        // async reset mid-packet after the 2nd of 4 flits
        step(1, 1, 0, hdr(3, T_E), E, S, 1, 0);
        step(1, 1, 0, 16'h0005,    E, S, 0, 0);
        @(posedge clk_i); #1;
        v_i = 1'b0; yumi_i = 1'b0;
        #1 reset_i = 1'b1;
        #5 reset_i = 1'b0;
        step(1, 1, 0, hdr(0, T_S), S, S, 1, 1);
        step(0, 0, 0, 16'h0000,    0, 0, 0, 0);

        @(posedge clk_i); #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
